gpio_irq_bank: RTL

- Parametrised next-generation GPIO bank on the APB slave register interface (gpio_wr_en/gpio_rd_en decoded by the APB bridge).
- Adds per-pin open-drain mode, configurable input synchroniser depth, and per-pin edge/level interrupts with W1C status and a single registered irq line.
- Pads are split into gpio_in/gpio_out/gpio_oe; the tri-state buffer lives in the pad ring.

---
 rtl/gpio_irq_bank.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/gpio_irq_bank.sv
// GPIO bank with per-pin direction, push-pull/open-drain drive, a configurable
// input synchroniser and per-pin edge/level interrupts. The W1C status feeds
// one registered irq line. The register port is the APB bridge's decoded
// strobe interface, with zero wait states.
module gpio_irq_bank #(
  parameter int NUM_PINS    = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    gpio_wr_en,
  input  logic                    gpio_rd_en,
  input  logic [ADDR_WIDTH-1:0]   gpio_reg_addr,
  input  logic [DATA_WIDTH-1:0]   gpio_wdata,
  input  logic [DATA_WIDTH/8-1:0] gpio_strb,
  output logic [DATA_WIDTH-1:0]   gpio_rdata,
  output logic                    gpio_ready,
  output logic                    gpio_error,
  input  logic [NUM_PINS-1:0]     gpio_in,
  output logic [NUM_PINS-1:0]     gpio_out,
  output logic [NUM_PINS-1:0]     gpio_oe,
  output logic                    irq
);

  // Register byte offsets
  localparam logic [ADDR_WIDTH-1:0] OFF_DIR      = ADDR_WIDTH'(8'h00);
  localparam logic [ADDR_WIDTH-1:0] OFF_IN       = ADDR_WIDTH'(8'h04);
  localparam logic [ADDR_WIDTH-1:0] OFF_OUT      = ADDR_WIDTH'(8'h08);
  localparam logic [ADDR_WIDTH-1:0] OFF_SET      = ADDR_WIDTH'(8'h0C);
  localparam logic [ADDR_WIDTH-1:0] OFF_CLR      = ADDR_WIDTH'(8'h10);
  localparam logic [ADDR_WIDTH-1:0] OFF_MODE     = ADDR_WIDTH'(8'h14);
  localparam logic [ADDR_WIDTH-1:0] OFF_INT_EN   = ADDR_WIDTH'(8'h18);
  localparam logic [ADDR_WIDTH-1:0] OFF_INT_TYPE = ADDR_WIDTH'(8'h1C);
  localparam logic [ADDR_WIDTH-1:0] OFF_INT_POL  = ADDR_WIDTH'(8'h20);
  localparam logic [ADDR_WIDTH-1:0] OFF_INT_STAT = ADDR_WIDTH'(8'h24);

  typedef enum logic [3:0] {
    SEL_DIR,
    SEL_IN,
    SEL_OUT,
    SEL_SET,
    SEL_CLR,
    SEL_MODE,
    SEL_INT_EN,
    SEL_INT_TYPE,
    SEL_INT_POL,
    SEL_INT_STAT,
    SEL_NONE
  } reg_sel_e;

  // Architectural state
  logic [NUM_PINS-1:0] dir_q;
  logic [NUM_PINS-1:0] out_q;
  logic [NUM_PINS-1:0] mode_q;
  logic [NUM_PINS-1:0] int_en_q;
  logic [NUM_PINS-1:0] int_type_q;
  logic [NUM_PINS-1:0] int_pol_q;
  logic [NUM_PINS-1:0] int_stat_q;

  // Input path: synchroniser chain and one-cycle edge history of IN
  logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_PINS-1:0] in_val;
  logic [NUM_PINS-1:0] prev_q;

  // Access decode
  reg_sel_e            sel;
  logic                bad_access;
  logic                wr_fire;
  logic [DATA_WIDTH-1:0] strb_mask;
  logic [NUM_PINS-1:0] pin_mask;
  logic [NUM_PINS-1:0] pin_wdata;

  // Interrupt datapath
  logic [NUM_PINS-1:0] evt;
  logic [NUM_PINS-1:0] stat_set;
  logic [NUM_PINS-1:0] stat_clr;
  logic [NUM_PINS-1:0] rd_val;

  // Bits of the bus above NUM_PINS carry no state; fold them here so the
  // narrower configurations do not leave dangling inputs.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{gpio_wdata, strb_mask};

  // Byte-lane merge: strobed bytes take new data, unstrobed bytes keep old.
  function automatic logic [NUM_PINS-1:0] merge(
    input logic [NUM_PINS-1:0] old_val,
    input logic [NUM_PINS-1:0] new_val,
    input logic [NUM_PINS-1:0] mask
  );
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  // Address decode to a register select.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    sel = SEL_NONE;
    case (gpio_reg_addr)
      OFF_DIR:      sel = SEL_DIR;
      OFF_IN:       sel = SEL_IN;
      OFF_OUT:      sel = SEL_OUT;
      OFF_SET:      sel = SEL_SET;
      OFF_CLR:      sel = SEL_CLR;
      OFF_MODE:     sel = SEL_MODE;
      OFF_INT_EN:   sel = SEL_INT_EN;
      OFF_INT_TYPE: sel = SEL_INT_TYPE;
      OFF_INT_POL:  sel = SEL_INT_POL;
      OFF_INT_STAT: sel = SEL_INT_STAT;
      default:      sel = SEL_NONE;
    endcase
  end

  // Unmapped addresses and writes to the read-only IN register are slave
  // errors; reading the write-only SET/CLR is legal and returns 0.
  assign bad_access = (sel == SEL_NONE) || (gpio_wr_en && (sel == SEL_IN));
  assign gpio_error = (gpio_wr_en || gpio_rd_en) && bad_access;
  assign wr_fire    = gpio_wr_en && !bad_access;
  assign gpio_ready = 1'b1;

  // Expand byte strobes into a bit mask covering the pin field.
  always_comb begin
    strb_mask = '0;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      strb_mask[8*b +: 8] = {8{gpio_strb[b]}};
    end
  end

  assign pin_mask  = strb_mask[NUM_PINS-1:0];
  assign pin_wdata = gpio_wdata[NUM_PINS-1:0];

  // Pad drive: open-drain pins never drive high, they release the pad instead.
  assign gpio_out = out_q & ~mode_q;
  assign gpio_oe  = dir_q & ~(mode_q & out_q);

  // Input synchroniser chain and edge-history register.
  always_ff @(posedge PCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the pre-edge value of the stage before it.
    if (PRESET) begin
      // NOTE: the synchroniser array is reset element by element; it is a
      // handful of flops, not a RAM, and must come out of reset at 0.
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      prev_q <= in_val;
    end
  end

  assign in_val = sync_q[SYNC_STAGES-1];

  // Per-pin event detection on the synchronised input.
  always_comb begin
    evt = (int_type_q  & ((int_pol_q & in_val & ~prev_q) | (~int_pol_q & ~in_val & prev_q)))
        | (~int_type_q & ((int_pol_q & in_val)           | (~int_pol_q & ~in_val)));
    stat_set = evt & int_en_q;
    stat_clr = '0;
    if (wr_fire && (sel == SEL_INT_STAT)) begin
      stat_clr = pin_wdata & pin_mask;
    end
  end

  // Configuration and output registers, written through the register port.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      dir_q      <= '0;
      out_q      <= '0;
      mode_q     <= '0;
      int_en_q   <= '0;
      int_type_q <= '0;
      int_pol_q  <= '0;
    end else if (wr_fire) begin
      case (sel)
        SEL_DIR:      dir_q      <= merge(dir_q, pin_wdata, pin_mask);
        SEL_OUT:      out_q      <= merge(out_q, pin_wdata, pin_mask);
        SEL_SET:      out_q      <= out_q | pin_wdata;
        SEL_CLR:      out_q      <= out_q & ~pin_wdata;
        SEL_MODE:     mode_q     <= merge(mode_q, pin_wdata, pin_mask);
        SEL_INT_EN:   int_en_q   <= merge(int_en_q, pin_wdata, pin_mask);
        SEL_INT_TYPE: int_type_q <= merge(int_type_q, pin_wdata, pin_mask);
        SEL_INT_POL:  int_pol_q  <= merge(int_pol_q, pin_wdata, pin_mask);
        default:      ;
      endcase
    end
  end

  // Interrupt status (set beats W1C on the same bit) and the registered irq.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      int_stat_q <= '0;
      irq        <= 1'b0;
    end else begin
      int_stat_q <= (int_stat_q & ~stat_clr) | stat_set;
      irq        <= |(int_stat_q & int_en_q);
    end
  end

  // Read mux: current register value, zero-extended, only while rd_en is high.
  always_comb begin
    rd_val = '0;
    case (sel)
      SEL_DIR:      rd_val = dir_q;
      SEL_IN:       rd_val = in_val;
      SEL_OUT:      rd_val = out_q;
      SEL_MODE:     rd_val = mode_q;
      SEL_INT_EN:   rd_val = int_en_q;
      SEL_INT_TYPE: rd_val = int_type_q;
      SEL_INT_POL:  rd_val = int_pol_q;
      SEL_INT_STAT: rd_val = int_stat_q;
      default:      rd_val = '0;
    endcase
    gpio_rdata = '0;
    if (gpio_rd_en) begin
      gpio_rdata[NUM_PINS-1:0] = rd_val;
    end
  end

endmodule
